// File: rtl/arm_fetch_if.sv
// Fetch unit bus: instruction-memory read port, branch redirect and decode-side handshake.
// master = fetch unit, slave = memory/execute/decode side.
interface arm_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      output imem_req, imem_addr, inst_valid, inst, inst_pc,
      input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst, inst_pc,
      output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
   );
endinterface

// File: rtl/arm_fetch.sv
// Instruction fetch: one outstanding imem read, DEPTH-entry {pc, word} prefetch queue,
// registered head presented to decode, branch redirect flushes and restarts fetch.
module arm_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   arm_fetch_if.master bus
);
   localparam int          PW  = $clog2(DEPTH);
   localparam int          CW  = PW + 1;
   localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state;
   logic          imem_req;
   logic [31:0]   imem_addr, fetch_pc, inst, inst_pc;
   logic [CW-1:0] count;
   logic [PW-1:0] head, tail;
   logic [31:0]   q_pc   [DEPTH];
   logic [31:0]   q_word [DEPTH];

   logic          ack, pop, push;
   logic [CW-1:0] cnt_pop, cnt_nxt;
   logic [PW-1:0] head_nxt;
   logic [31:0]   rpc, addr_inc;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // An ack only counts against a live request; stray acks while idle are dropped.
   assign ack      = bus.imem_ack & imem_req;
   assign pop      = (count != '0) & bus.inst_ready & ~bus.redirect;
   assign push     = ack & (state == WAIT) & ~bus.redirect;
   assign cnt_pop  = count - CW'(pop);
   assign cnt_nxt  = cnt_pop + CW'(push);
   assign head_nxt = pop ? ptr_inc(head) : head;
   assign rpc      = {bus.redirect_pc[31:2], 2'b00};
   assign addr_inc = imem_addr + 32'd4;

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[tail]   <= imem_addr;
         q_word[tail] <= bus.imem_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         imem_req  <= 1'b0;
         imem_addr <= PC0;
         fetch_pc  <= PC0;
         count     <= '0;
         head      <= '0;
         tail      <= '0;
         inst      <= '0;
         inst_pc   <= '0;
      end else begin
         if (bus.redirect) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
         end else begin
            count <= cnt_nxt;
            head  <= head_nxt;
            if (push) tail <= ptr_inc(tail);
            // Head register tracks the post-update head; an empty queue keeps the last value.
            if (cnt_pop != '0) begin
               inst    <= q_word[head_nxt];
               inst_pc <= q_pc[head_nxt];
            end else if (push) begin
               inst    <= bus.imem_rdata;
               inst_pc <= imem_addr;
            end
         end

         case (state)
            IDLE: begin
               if (bus.redirect) begin
                  fetch_pc  <= rpc;
                  imem_addr <= rpc;
                  imem_req  <= 1'b1;
                  state     <= WAIT;
               end else if (cnt_pop < CW'(DEPTH)) begin
                  imem_addr <= fetch_pc;
                  imem_req  <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (bus.redirect) begin
                  fetch_pc <= rpc;
                  if (ack) imem_addr <= rpc;
                  else     state     <= DROP;
               end else if (ack) begin
                  fetch_pc <= addr_inc;
                  if (cnt_nxt < CW'(DEPTH)) begin
                     imem_addr <= addr_inc;
                  end else begin
                     imem_req <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            DROP: begin
               // Old request must still complete; its data is thrown away.
               if (bus.redirect) fetch_pc <= rpc;
               if (ack) begin
                  imem_addr <= bus.redirect ? rpc : fetch_pc;
                  state     <= WAIT;
               end
            end
            default: begin
               imem_req <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.imem_req   = imem_req;
   assign bus.imem_addr  = imem_addr;
   assign bus.inst_valid = (count != '0);
   assign bus.inst       = inst;
   assign bus.inst_pc    = inst_pc;
endmodule

// File: tb/tb_arm_fetch.sv
// Bench for arm_fetch: memory model with programmable latency, scoreboard of expected
// {pc, word} built from the bench's own fetch-address model, redirect vector table.
`timescale 1ns/1ps
module tb_arm_fetch;
   localparam logic [31:0] RPC = 32'h0000_0103;

   typedef struct packed { logic [31:0] pc; logic [31:0] w; } ent_t;
   typedef struct { logic [31:0] rpc; int lat; bit stall; logic [31:0] pc0; logic [31:0] pc1; } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   arm_fetch_if bus();
   arm_fetch #(.RESET_PC(RPC), .DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

   int          tests = 0, fails = 0;
   int          lat = 0, wcnt = 0, acc_cnt = 0;
   bit          stray = 1'b0, stale = 1'b0;
   bit          prev_req = 1'b0, prev_ack = 1'b0;
   logic [31:0] prev_addr = '0, exp_fetch = {RPC[31:2], 2'b00};
   ent_t        sbq[$];
   logic [31:0] log_pc[$], log_w[$];
   vec_t        tbl[5];

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'hE201_1002;
         32'h0000_0104: return 32'hE3C8_9CFF;
         32'h0000_0108: return 32'hE083_4002;
         32'h0000_0200: return 32'hEB00_000A;
         default:       return 32'hE1A0_0000 ^ {a[17:2], a[31:16]};
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_log(input int n, input string name);
      int k = 0;
      while (log_pc.size() < n && k < 200) begin @(negedge clk); k++; end
      if (log_pc.size() < n) begin
         tests++; fails++;
         $display("FAIL %s timeout: got %0d insts, expected %0d", name, log_pc.size(), n);
      end
   endtask

   task automatic wait_addr(input logic [31:0] a, input string name);
      int k = 0;
      while (!(bus.imem_req && bus.imem_addr == a) && k < 200) begin @(negedge clk); k++; end
      check(name, bus.imem_addr, a);
   endtask

   task automatic log_clear();
      log_pc.delete();
      log_w.delete();
   endtask

   // Memory: ack after `lat` idle cycles of a live request; `stray` forces a bogus ack.
   initial begin
      bus.imem_ack = 1'b0; bus.imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (wcnt > lat) wcnt = lat;
         if (stray) begin
            bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; wcnt = lat;
         end else if (reset || !bus.imem_req) begin
            bus.imem_ack = 1'b0; wcnt = lat;
         end else if (wcnt <= 0) begin
            bus.imem_ack = 1'b1; bus.imem_rdata = mem(bus.imem_addr); wcnt = lat;
         end else begin
            bus.imem_ack = 1'b0; wcnt--;
         end
      end
   end

   // Monitor: inputs are settled here, so model what the coming rising edge will do.
   initial begin
      forever begin
         @(negedge clk); #1;
         if (reset) begin
            sbq.delete(); exp_fetch = {RPC[31:2], 2'b00}; stale = 1'b0;
            prev_req = 1'b0; prev_ack = 1'b0;
         end else begin
            check("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
            if (prev_req && !prev_ack) begin
               check("req_hold", 32'(bus.imem_req), 32'd1);
               check("addr_hold", bus.imem_addr, prev_addr);
            end
            if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
               if (sbq.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL pop_unexpected: got pc %h, expected no instruction", bus.inst_pc);
               end else begin
                  ent_t e;
                  e = sbq.pop_front();
                  check("pop_pc", bus.inst_pc, e.pc);
                  check("pop_inst", bus.inst, e.w);
               end
               log_pc.push_back(bus.inst_pc);
               log_w.push_back(bus.inst);
            end
            if (bus.imem_req && bus.imem_ack) begin
               acc_cnt++;
               if (stale) stale = 1'b0;
               else if (!bus.redirect) begin
                  ent_t e;
                  check("fetch_addr", bus.imem_addr, exp_fetch);
                  e.pc = exp_fetch; e.w = mem(exp_fetch);
                  sbq.push_back(e);
                  exp_fetch = exp_fetch + 32'd4;
               end
            end
            if (bus.redirect) begin
               sbq.delete();
               exp_fetch = {bus.redirect_pc[31:2], 2'b00};
               stale = bus.imem_req && !bus.imem_ack;
            end
            prev_req  = bus.imem_req;
            prev_ack  = bus.imem_req && bus.imem_ack;
            prev_addr = bus.imem_addr;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{32'hFFFF_FFFC, 0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
      tbl[1] = '{32'h0000_1002, 1, 1'b0, 32'h0000_1000, 32'h0000_1004};
      tbl[2] = '{32'h0000_0101, 2, 1'b1, 32'h0000_0100, 32'h0000_0104};
      tbl[3] = '{32'h8000_0003, 0, 1'b0, 32'h8000_0000, 32'h8000_0004};
      tbl[4] = '{32'hFFFF_FFFF, 3, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000};

      bus.redirect = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b1;
      reset = 1'b1;
      cyc(2);
      check("rst_req",   32'(bus.imem_req),   32'd0);
      check("rst_addr",  bus.imem_addr,       32'h100);
      check("rst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst",  bus.inst,            32'd0);
      check("rst_pc",    bus.inst_pc,         32'd0);

      // reset fetch, zero-wait memory
      reset = 1'b0;
      @(negedge clk);
      check("rf_req0",  32'(bus.imem_req),   32'd1);
      check("rf_addr0", bus.imem_addr,       32'h100);
      check("rf_val0",  32'(bus.inst_valid), 32'd0);
      @(negedge clk);
      check("rf_addr1", bus.imem_addr, 32'h104);
      check("rf_inst1", bus.inst,      32'hE201_1002);
      check("rf_pc1",   bus.inst_pc,   32'h100);
      @(negedge clk);
      check("rf_addr2", bus.imem_addr, 32'h108);
      check("rf_inst2", bus.inst,      32'hE3C8_9CFF);
      check("rf_pc2",   bus.inst_pc,   32'h104);
      @(negedge clk);
      check("rf_inst3", bus.inst,      32'hE083_4002);
      check("rf_pc3",   bus.inst_pc,   32'h108);

      // backpressure
      reset = 1'b1; bus.inst_ready = 1'b0;
      cyc(2);
      log_clear(); acc_cnt = 0; reset = 1'b0;
      cyc(10);
      check("bp_acks",  32'(acc_cnt),        32'd2);
      check("bp_req",   32'(bus.imem_req),   32'd0);
      check("bp_valid", 32'(bus.inst_valid), 32'd1);
      check("bp_inst",  bus.inst,            32'hE201_1002);
      check("bp_pc",    bus.inst_pc,         32'h100);
      bus.inst_ready = 1'b1;
      wait_log(5, "bp_resume");
      for (int i = 0; i < 5 && i < log_pc.size(); i++) begin
         check("bp_seq_pc",   log_pc[i], 32'h100 + 32'(4 * i));
         check("bp_seq_inst", log_w[i],  mem(32'h100 + 32'(4 * i)));
      end

      // redirect in the first cycle of a slow request
      reset = 1'b1; lat = 3;
      cyc(2);
      reset = 1'b0;
      wait_addr(32'h104, "rw_wait");
      bus.redirect = 1'b1; bus.redirect_pc = 32'h200; log_clear();
      @(negedge clk);
      bus.redirect = 1'b0;
      check("rw_flush", 32'(bus.inst_valid), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("rw_req_held",  32'(bus.imem_req), 32'd1);
         check("rw_addr_held", bus.imem_addr,     32'h104);
         @(negedge clk);
      end
      check("rw_new_addr", bus.imem_addr, 32'h200);
      wait_log(2, "rw_stream");
      if (log_pc.size() >= 2) begin
         check("rw_pc0",   log_pc[0], 32'h200);
         check("rw_inst0", log_w[0],  32'hEB00_000A);
         check("rw_pc1",   log_pc[1], 32'h204);
      end

      // redirect on the same edge as an ack
      lat = 0;
      cyc(6);
      bus.redirect = 1'b1; bus.redirect_pc = 32'h203; log_clear();
      @(negedge clk);
      bus.redirect = 1'b0;
      check("co_valid", 32'(bus.inst_valid), 32'd0);
      check("co_req",   32'(bus.imem_req),   32'd1);
      check("co_addr",  bus.imem_addr,       32'h200);
      wait_log(2, "co_stream");
      if (log_pc.size() >= 2) begin
         check("co_pc0",   log_pc[0], 32'h200);
         check("co_inst0", log_w[0],  32'hEB00_000A);
      end

      // redirect vectors
      for (int i = 0; i < 5; i++) begin
         lat = tbl[i].lat;
         if (tbl[i].stall) begin
            bus.inst_ready = 1'b0;
            cyc(8);
         end
         bus.inst_ready = 1'b1;
         bus.redirect = 1'b1; bus.redirect_pc = tbl[i].rpc; log_clear();
         @(negedge clk);
         bus.redirect = 1'b0;
         check("tv_flush", 32'(bus.inst_valid), 32'd0);
         wait_log(3, "tv_stream");
         if (log_pc.size() >= 2) begin
            check("tv_pc0",   log_pc[0], tbl[i].pc0);
            check("tv_inst0", log_w[0],  mem(tbl[i].pc0));
            check("tv_pc1",   log_pc[1], tbl[i].pc1);
            check("tv_inst1", log_w[1],  mem(tbl[i].pc1));
         end
      end

      // async reset while waiting with one entry queued
      lat = 3; bus.inst_ready = 1'b0; reset = 1'b1;
      cyc(2);
      log_clear(); reset = 1'b0;
      wait_addr(32'h104, "ar_wait");
      check("ar_pre_valid", 32'(bus.inst_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("ar_req",   32'(bus.imem_req),   32'd0);
      check("ar_valid", 32'(bus.inst_valid), 32'd0);
      stray = 1'b1;
      cyc(2);
      check("ar_stray_inst",  bus.inst,            32'd0);
      check("ar_stray_pc",    bus.inst_pc,         32'd0);
      check("ar_stray_valid", 32'(bus.inst_valid), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      stray = 1'b0; lat = 0; bus.inst_ready = 1'b1;
      @(negedge clk);
      check("ar_req1",  32'(bus.imem_req),   32'd1);
      check("ar_addr1", bus.imem_addr,       32'h100);
      check("ar_val1",  32'(bus.inst_valid), 32'd0);
      check("ar_inst1", bus.inst,            32'd0);
      wait_log(2, "ar_stream");
      if (log_pc.size() >= 2) begin
         check("ar_pc0",   log_pc[0], 32'h100);
         check("ar_inst0", log_w[0],  32'hE201_1002);
         check("ar_pc1",   log_pc[1], 32'h104);
      end

      cyc(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
